accum_drain_requant: RTL

- Controller and reader on the far side of the per-picture accumulator.
- Counts kernel-tap beats and drives the accumulator's First_Compute_Complete restart pulse.
- Captures the finished 32-bit sums, then adds bias, rounds, shifts, applies optional ReLU and saturates to signed 8-bit.
- Queues the results in a small FIFO with a valid/ready output toward the output writer.

---
 rtl/accum_drain_requant.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/accum_drain_requant.sv
// accum_drain_requant
//   Sits behind the per-picture accumulator. It counts kernel-tap beats and
//   issues the accumulator restart pulse (First_Compute_Complete). When a
//   group finishes, it captures the 32-bit sums, adds the bias, rounds and
//   shifts them, applies an optional ReLU and saturates each lane to a signed
//   WIDTH_OUT value. Results are queued in a small FIFO drained by valid/ready.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   beat_valid/beat_ready    multiply-beat handshake from upstream
//   First_Compute_Complete   combinational restart pulse on a group's first beat
//   M_Data_in                accumulator lanes, PICTURE_NUM x WIDTH_DATA_ADD, signed
//   tap_num, bias_in,        group config, sampled on the first beat of a group
//   shift_amt, relu_en
//   m_valid/m_ready/m_data   FIFO head toward the output writer
//   group_done               one-cycle pulse when a result enters the FIFO
module accum_drain_requant #(
  parameter int unsigned PICTURE_NUM    = 8,
  parameter int unsigned WIDTH_DATA_ADD = 32,
  parameter int unsigned WIDTH_OUT      = 8,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  beat_valid,
  output logic                                  beat_ready,
  output logic                                  First_Compute_Complete,
  input  logic [PICTURE_NUM*WIDTH_DATA_ADD-1:0] M_Data_in,
  input  logic [15:0]                           tap_num,
  input  logic [PICTURE_NUM*WIDTH_DATA_ADD-1:0] bias_in,
  input  logic [4:0]                            shift_amt,
  input  logic                                  relu_en,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [PICTURE_NUM*WIDTH_OUT-1:0]      m_data,
  output logic                                  group_done
);

  localparam int unsigned W   = WIDTH_DATA_ADD;
  localparam int unsigned S1W = W + 1;  // sum + bias
  localparam int unsigned RW  = W + 2;  // sum + bias + rounding constant
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned OW  = CW + 1;
  localparam int unsigned DW  = PICTURE_NUM * WIDTH_OUT;

  localparam logic signed [RW-1:0] OutMax = RW'((1 << (WIDTH_OUT - 1)) - 1);
  localparam logic signed [RW-1:0] OutMin = ~OutMax;
  localparam logic [OW-1:0]        DepthW = OW'(FIFO_DEPTH);

  // Beat counting and group config
  logic [15:0]            cnt_q, cnt_d, tap_q, tap_eff;
  logic [PICTURE_NUM*W-1:0] bias_q;
  logic [4:0]             shift_q;
  logic                   relu_q;
  logic                   accept, first_beat, last_beat;

  // Pipeline
  logic                   pend_q, s1_valid_q, group_done_q;
  logic signed [S1W-1:0]  s1_q [PICTURE_NUM];
  logic [4:0]             s1_shift_q;
  logic                   s1_relu_q;
  logic [DW-1:0]          res;
  logic signed [RW-1:0]   rnd, r;

  // FIFO
  logic [DW-1:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]          rd_q, wr_q;
  logic [CW-1:0]          fcnt_q, fcnt_d;
  logic [DW-1:0]          m_data_q, head_d;
  logic                   push, pop;
  logic [OW-1:0]          occ;

  assign tap_eff    = (tap_num == 16'd0) ? 16'd1 : tap_num;
  assign accept     = beat_valid && beat_ready;
  assign first_beat = accept && (cnt_q == 16'd0);
  assign last_beat  = accept && ((cnt_q == 16'd0) ? (tap_eff == 16'd1)
                                                  : (cnt_q == tap_q - 16'd1));
  assign cnt_d      = last_beat ? 16'd0 : cnt_q + 16'd1;

  assign First_Compute_Complete = first_beat;

  // Every accepted beat or in-flight result reserves a FIFO slot.
  assign occ        = OW'(fcnt_q) + OW'(pend_q) + OW'(s1_valid_q);
  assign beat_ready = occ < DepthW;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      tap_q   <= 16'd1;
      bias_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      if (accept) cnt_q <= cnt_d;
      if (first_beat) begin
        tap_q   <= tap_eff;
        bias_q  <= bias_in;
        shift_q <= shift_amt;
        relu_q  <= relu_en;
      end
    end
  end

  // Stage 1: the accumulator holds the full sum the cycle after the last beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      group_done_q <= 1'b0;
      s1_shift_q   <= '0;
      s1_relu_q    <= 1'b0;
      for (int i = 0; i < PICTURE_NUM; i++) s1_q[i] <= '0;
    end else begin
      pend_q       <= last_beat;
      s1_valid_q   <= pend_q;
      group_done_q <= s1_valid_q;
      if (pend_q) begin
        // shift/relu travel with the data so a new group may relatch config
        s1_shift_q <= shift_q;
        s1_relu_q  <= relu_q;
        for (int i = 0; i < PICTURE_NUM; i++) begin
          s1_q[i] <= {M_Data_in[i*W+W-1], M_Data_in[i*W +: W]}
                   + {bias_q[i*W+W-1], bias_q[i*W +: W]};
        end
      end
    end
  end

  // Stage 2: round half up, arithmetic shift, ReLU, saturate.
  always_comb begin
    res = '0;
    rnd = '0;
    r   = '0;
    for (int i = 0; i < PICTURE_NUM; i++) begin
      rnd = '0;
      if (s1_shift_q != 5'd0) rnd = {{(RW-1){1'b0}}, 1'b1} << (s1_shift_q - 5'd1);
      r = ($signed({s1_q[i][S1W-1], s1_q[i]}) + rnd) >>> s1_shift_q;
      if (s1_relu_q && (r < 0)) r = '0;
      if (r > OutMax) begin
        res[i*WIDTH_OUT +: WIDTH_OUT] = OutMax[WIDTH_OUT-1:0];
      end else if (r < OutMin) begin
        res[i*WIDTH_OUT +: WIDTH_OUT] = OutMin[WIDTH_OUT-1:0];
      end else begin
        res[i*WIDTH_OUT +: WIDTH_OUT] = r[WIDTH_OUT-1:0];
      end
    end
  end

  // Output FIFO. beat_ready throttling guarantees a free slot on every push.
  assign push    = s1_valid_q;
  assign m_valid = (fcnt_q != '0);
  assign pop     = m_valid && m_ready;
  assign fcnt_d  = fcnt_q + CW'(push) - CW'(pop);

  // Registered head: next head is the incoming word when it lands in an
  // otherwise empty FIFO; an empty FIFO keeps the last word shown.
  always_comb begin
    head_d = m_data_q;
    if (fcnt_d != '0) begin
      if ((fcnt_q - CW'(pop)) == '0) head_d = res;
      else                           head_d = mem[rd_q + PW'(pop)];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= res;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q     <= '0;
      wr_q     <= '0;
      fcnt_q   <= '0;
      m_data_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      fcnt_q   <= fcnt_d;
      m_data_q <= head_d;
    end
  end

  assign m_data     = m_data_q;
  assign group_done = group_done_q;

endmodule
